// File: rtl/ctrl_pipe_pkg.sv
// Control-bundle layout shared by the ID/EX..MEM/WB register chain.
// Fields are packed MSB-first; offsets build up from L at bit 0.
package ctrl_pipe_pkg;

   localparam int SOH_OP_W = 3;
   localparam int ALU_OP_W = 3;
   localparam int RW_W     = 5;
   localparam int SIZE_W   = 2;

   localparam int L_OFF      = 0;
   localparam int B_OFF      = L_OFF + 1;
   localparam int ID_SR_OFF  = B_OFF + 1;
   localparam int RF_LE_OFF  = ID_SR_OFF + 1;
   localparam int CALL_OFF   = RF_LE_OFF + 1;
   localparam int J_L_OFF    = CALL_OFF + 1;
   localparam int USE_CC_OFF = J_L_OFF + 1;
   localparam int CC_WE_OFF  = USE_CC_OFF + 1;
   localparam int SIZE_OFF   = CC_WE_OFF + 1;
   localparam int E_OFF      = SIZE_OFF + SIZE_W;
   localparam int RW_OFF     = E_OFF + 1;
   localparam int ALU_OP_OFF = RW_OFF + RW_W;
   localparam int SOH_OP_OFF = ALU_OP_OFF + ALU_OP_W;
   localparam int CTRL_W     = SOH_OP_OFF + SOH_OP_W;

   typedef struct packed {
      logic [SOH_OP_W-1:0] soh_op;
      logic [ALU_OP_W-1:0] alu_op;
      logic [RW_W-1:0]     rw;
      logic                e;
      logic [SIZE_W-1:0]   size;
      logic                cc_we;
      logic                use_cc;
      logic                j_l;
      logic                call;
      logic                rf_le;
      logic                id_sr;
      logic                b;
      logic                l;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_chain_stage.sv
// One control-bundle pipeline register with flush > hold > bubble > load priority.
// Latency 1 edge; a held stage keeps its contents, a flush overrides the hold.
module ctrl_pipe_stage
   import ctrl_pipe_pkg::*;
#(
   parameter int             W         = CTRL_W,
   parameter logic [W-1:0]   NOP_VALUE = W'(CTRL_NOP)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         hold,
   input  logic         bubble,
   input  logic [W-1:0] up_dat,
   input  logic         up_vld,
   output logic [W-1:0] dat,
   output logic         vld
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dat <= NOP_VALUE;
         vld <= 1'b0;
      end else if (flush) begin
         dat <= NOP_VALUE;
         vld <= 1'b0;
      end else if (!hold) begin
         // An invalid upstream slot is normalised to NOP so valid=0 always means NOP contents.
         if (bubble || !up_vld) begin
            dat <= NOP_VALUE;
            vld <= 1'b0;
         end else begin
            dat <= up_dat;
            vld <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Control-bundle register chain ID/EX..MEM/WB: stage k sees ctrl_i k+1 edges after accept_o.
// Holds freeze the stage and everything upstream; optional bubble counter under CTRL_PIPE_BUBBLE_CNT_EN.
module ctrl_pipe_chain
   import ctrl_pipe_pkg::*;
#(
   parameter int             W         = CTRL_W,
   parameter int             STAGES    = 3,
   parameter logic [W-1:0]   NOP_VALUE = W'(CTRL_NOP),
   parameter int             CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [W-1:0]          ctrl_i,
   input  logic                  valid_i,
   input  logic [STAGES-1:0]     hold_i,
   input  logic [STAGES-1:0]     flush_i,
`ifdef CTRL_PIPE_BUBBLE_CNT_EN
   input  logic                  clr_cnt_i,
   output logic [CNT_W-1:0]      bubble_cnt_o,
`endif
   output logic                  accept_o,
   output logic [STAGES*W-1:0]   ctrl_o,
   output logic [STAGES-1:0]     valid_o
);

   logic [STAGES-1:0] eh;
   logic [W-1:0]      st_dat [STAGES];
   logic              st_vld [STAGES];

   // A stall at stage k also freezes every stage upstream of it.
   always_comb begin
      eh = '0;
      for (int k = 0; k < STAGES; k++) begin
         eh[k] = |(hold_i >> k);
      end
   end

   assign accept_o = ~eh[0] & ~flush_i[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [W-1:0] up_dat;
      logic         up_vld;
      logic         bubble;

      if (k == 0) begin : g_head
         assign up_dat = ctrl_i;
         assign up_vld = valid_i;
         assign bubble = 1'b0;
      end else begin : g_body
         assign up_dat = st_dat[k-1];
         assign up_vld = st_vld[k-1];
         assign bubble = hold_i[k-1] | flush_i[k-1];
      end

      ctrl_pipe_stage #(
         .W         (W),
         .NOP_VALUE (NOP_VALUE)
      ) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .flush  (flush_i[k]),
         .hold   (eh[k]),
         .bubble (bubble),
         .up_dat (up_dat),
         .up_vld (up_vld),
         .dat    (st_dat[k]),
         .vld    (st_vld[k])
      );

      assign ctrl_o[k*W +: W] = st_dat[k];
      assign valid_o[k]       = st_vld[k];
   end

`ifdef CTRL_PIPE_BUBBLE_CNT_EN
   logic [STAGES-1:0] hold_bub;
   logic [CNT_W-1:0]  cnt;

   // Stage k only takes a hold-induced bubble when it actually advances.
   always_comb begin
      hold_bub = '0;
      for (int k = 1; k < STAGES; k++) begin
         hold_bub[k] = hold_i[k-1] & ~eh[k] & ~flush_i[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr_cnt_i) begin
         cnt <= '0;
      end else if (((|hold_bub) || (|flush_i)) && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bubble_cnt_o = cnt;
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Scoreboarded bench for ctrl_pipe_chain: directed scenarios then random hold/flush traffic.
// Enable CTRL_PIPE_BUBBLE_CNT_EN at compile time to also check the bubble counter.
module tb_ctrl_pipe_chain;
   localparam int W  = 22;
   localparam int S  = 3;
   localparam int CW = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [W-1:0]   ctrl_i;
   logic           valid_i;
   logic [S-1:0]   hold_i;
   logic [S-1:0]   flush_i;
   logic           clr_cnt_i;
   logic           accept_o;
   logic [S*W-1:0] ctrl_o;
   logic [S-1:0]   valid_o;
   logic [CW-1:0]  bubble_cnt_o;

   always #5 clk = ~clk;

   ctrl_pipe_chain #(.W(W), .STAGES(S), .NOP_VALUE('0), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ctrl_i       (ctrl_i),
      .valid_i      (valid_i),
      .hold_i       (hold_i),
      .flush_i      (flush_i),
`ifdef CTRL_PIPE_BUBBLE_CNT_EN
      .clr_cnt_i    (clr_cnt_i),
      .bubble_cnt_o (bubble_cnt_o),
`endif
      .accept_o     (accept_o),
      .ctrl_o       (ctrl_o),
      .valid_o      (valid_o)
   );

`ifndef CTRL_PIPE_BUBBLE_CNT_EN
   assign bubble_cnt_o = '0;
`endif

   typedef struct packed {
      logic [S*W-1:0] dat;
      logic [S-1:0]   vld;
      logic [CW-1:0]  cnt;
   } snap_t;

   snap_t  st_q [$];
   logic   acc_q [$];
   logic   mon_en = 1'b0;
   int     n_chk = 0;
   int     n_pass = 0;

   // Reference: one slot per stage holding the instruction currently there.
   logic [W-1:0] m_dat [S];
   logic         m_vld [S];
   int           m_cnt;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic snap_t snap();
      snap_t s;
      for (int k = 0; k < S; k++) begin
         s.dat[k*W +: W] = m_dat[k];
         s.vld[k]        = m_vld[k];
      end
      s.cnt = CW'(m_cnt);
      return s;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < S; k++) begin
         m_dat[k] = '0;
         m_vld[k] = 1'b0;
      end
      m_cnt = 0;
   endtask

   function automatic logic stalled(input int k, input logic [S-1:0] h);
      for (int j = k; j < S; j++) if (h[j]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge(input logic [W-1:0] c, input logic v, input logic [S-1:0] h,
                             input logic [S-1:0] f, input logic clr);
      logic [W-1:0] nd [S];
      logic         nv [S];
      logic         evt;
      evt = |f;
      for (int k = 0; k < S; k++) begin
         nd[k] = m_dat[k];
         nv[k] = m_vld[k];
         if (f[k]) begin
            nd[k] = '0; nv[k] = 1'b0;
         end else if (!stalled(k, h)) begin
            if (k == 0) begin
               nd[k] = v ? c : '0; nv[k] = v;
            end else if (h[k-1] || f[k-1]) begin
               nd[k] = '0; nv[k] = 1'b0;
               if (h[k-1]) evt = 1'b1;
            end else begin
               nd[k] = m_dat[k-1]; nv[k] = m_vld[k-1];
            end
         end
      end
      for (int k = 0; k < S; k++) begin
         m_dat[k] = nd[k];
         m_vld[k] = nv[k];
      end
      if (clr) m_cnt = 0;
      else if (evt && m_cnt < (1 << CW) - 1) m_cnt++;
   endtask

   // Drive one cycle of inputs just after a rising edge and queue what the DUT must show.
   task automatic step(input logic [W-1:0] c, input logic v, input logic [S-1:0] h,
                       input logic [S-1:0] f, input logic clr);
      ctrl_i = c; valid_i = v; hold_i = h; flush_i = f; clr_cnt_i = clr;
      acc_q.push_back(!stalled(0, h) && !f[0]);
      model_edge(c, v, h, f, clr);
      st_q.push_back(snap());
      @(posedge clk);
      #1;
   endtask

   snap_t mon_e;
   logic  mon_a;
   always @(negedge clk) begin
      if (mon_en) begin
         if (acc_q.size() > 0) begin
            mon_a = acc_q.pop_front();
            chk("accept_o", 128'(accept_o), 128'(mon_a));
         end
         if (st_q.size() > 0) begin
            mon_e = st_q.pop_front();
            chk("ctrl_o", 128'(ctrl_o), 128'(mon_e.dat));
            chk("valid_o", 128'(valid_o), 128'(mon_e.vld));
`ifdef CTRL_PIPE_BUBBLE_CNT_EN
            chk("bubble_cnt_o", 128'(bubble_cnt_o), 128'(mon_e.cnt));
`endif
         end
      end
   end

   task automatic idle_inputs();
      ctrl_i = '0; valid_i = 1'b0; hold_i = '0; flush_i = '0; clr_cnt_i = 1'b0;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset ctrl_o", 128'(ctrl_o), 128'(0));
      chk("reset valid_o", 128'(valid_o), 128'(0));
`ifdef CTRL_PIPE_BUBBLE_CNT_EN
      chk("reset bubble_cnt_o", 128'(bubble_cnt_o), 128'(0));
`endif
      idle_inputs();
      st_q.delete();
      acc_q.delete();
      model_reset();
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      st_q.push_back(snap());
      mon_en = 1'b1;
   endtask

   logic [W-1:0] rc;
   logic         rv;
   logic [S-1:0] rh, rf;
   logic         last_acc;

   initial begin
      idle_inputs();
      rst_n = 1'b1;
      #1 do_reset();

      // Free flow
      step(22'h0000A1, 1, 3'b000, 3'b000, 0);
      step(22'h0000B2, 1, 3'b000, 3'b000, 0);
      step(22'h0000C3, 1, 3'b000, 3'b000, 0);
      step('0, 0, 3'b000, 3'b000, 0);
      step('0, 0, 3'b000, 3'b000, 0);
      // Mid-stall with A in stage 1, B in stage 0
      step(22'h00AAAA, 1, 3'b000, 3'b000, 0);
      step(22'h00BBBB, 1, 3'b000, 3'b000, 0);
      step(22'h00CCCC, 1, 3'b010, 3'b000, 0);
      step(22'h00CCCC, 1, 3'b010, 3'b000, 0);
      step(22'h00CCCC, 1, 3'b000, 3'b000, 0);
      // Flush priority over hold, then downstream squash
      step(22'h00DDDD, 1, 3'b011, 3'b001, 0);
      step(22'h00DDDD, 1, 3'b000, 3'b010, 0);
      step(22'h00EEEE, 1, 3'b000, 3'b000, 0);
      // All holds, then all flushes
      step(22'h00FFFF, 1, 3'b111, 3'b000, 0);
      step(22'h00FFFF, 1, 3'b000, 3'b111, 0);
      // Saturate the counter, then clear it
      for (int i = 0; i < 20; i++) step('0, 0, 3'b000, 3'b001, 0);
      step('0, 0, 3'b000, 3'b000, 1);
      step('0, 0, 3'b000, 3'b000, 0);
      // Reset with three valid bundles in flight
      step(22'h012345, 1, 3'b000, 3'b000, 0);
      step(22'h00ABCD, 1, 3'b000, 3'b000, 0);
      step(22'h000F0F, 1, 3'b000, 3'b000, 0);
      do_reset();

      last_acc = 1'b1;
      rc = '0;
      rv = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (last_acc) begin
            rc = W'($urandom);
            rv = ($urandom_range(0, 9) < 8);
         end
         for (int k = 0; k < S; k++) begin
            rh[k] = ($urandom_range(0, 99) < 15);
            rf[k] = ($urandom_range(0, 99) < 7);
         end
         last_acc = !(|rh) && !rf[0];
         step(rc, rv, rh, rf, ($urandom_range(0, 99) < 3));
      end
      step('0, 0, 3'b000, 3'b000, 0);
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
